logical_ops: RTL and testbench

- Registered 16-bit bitwise logic unit for the datapath. It takes operands A, B and a 3-bit opcode and produces one result per accepted input.
- Used as the logic slice beside the adder/shifter units; one-cycle latency, valid-qualified.

---
 rtl/logical_ops.sv | 111 +++++++++++
 tb/tb_logical_ops.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/logical_ops.sv
// Registered WIDTH-bit bitwise logic unit: AND/OR/NOT/XOR/NAND/NOR/XNOR and 2s complement of A.
// Latency 1 cycle, one result per accepted input, no backpressure; out/zero hold while idle.
// Define LOGICAL_OPS_FLAGS_EN to add registered neg/parity/ovf outputs.
module logical_ops #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
`ifdef LOGICAL_OPS_FLAGS_EN
    output logic             neg,
    output logic             parity,
    output logic             ovf,
`endif
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_NEG  = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] out_d, out_q;
    logic             vld_d, vld_q;
    logic             zero_d, zero_q;
    op_e              op;

    assign op = op_e'(Operation);

    // B is never consulted for NOT / 2s complement, so an X on B cannot leak into those results.
    always_comb begin
        out_d = '0;
        case (op)
            OP_AND:  out_d = A & B;
            OP_OR:   out_d = A | B;
            OP_NOT:  out_d = ~A;
            OP_XOR:  out_d = A ^ B;
            OP_NAND: out_d = ~(A & B);
            OP_NOR:  out_d = ~(A | B);
            OP_XNOR: out_d = ~(A ^ B);
            OP_NEG:  out_d = ~A + ONE;
            default: out_d = '0;
        endcase
        vld_d  = in_valid;
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            vld_q <= vld_d;
            if (in_valid) begin
                out_q  <= out_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign zero      = zero_q;

`ifdef LOGICAL_OPS_FLAGS_EN
    logic neg_d, neg_q;
    logic parity_d, parity_q;
    logic ovf_d, ovf_q;

    always_comb begin
        neg_d    = out_d[WIDTH-1];
        parity_d = ^out_d;
        ovf_d    = (op == OP_NEG) && (A == MOST_NEG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q    <= 1'b0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (in_valid) begin
            neg_q    <= neg_d;
            parity_q <= parity_d;
            ovf_q    <= ovf_d;
        end
    end

    assign neg    = neg_q;
    assign parity = parity_q;
    assign ovf    = ovf_q;
`else
    logic unused_most_neg;
    assign unused_most_neg = ^MOST_NEG;
`endif

endmodule

// File: tb/tb_logical_ops.sv
// Self-checking bench for logical_ops: directed vectors then randomized traffic against a reference model.
// Flag outputs are exercised when LOGICAL_OPS_FLAGS_EN is defined.
module tb_logical_ops;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Operation;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
`ifdef LOGICAL_OPS_FLAGS_EN
    logic             neg;
    logic             parity;
    logic             ovf;
`endif

    logical_ops #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Operation (Operation),
        .out       (out),
        .out_valid (out_valid),
`ifdef LOGICAL_OPS_FLAGS_EN
        .neg       (neg),
        .parity    (parity),
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected state of the registered outputs.
    int exp_out;
    bit exp_vld;
    bit exp_zero;
    bit exp_neg;
    bit exp_par;
    bit exp_ovf;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: opcode meanings written as plain integer arithmetic on 16-bit values.
    function automatic int ref_result(input int a, input int b, input int op);
        int m;
        m = 65535;
        case (op)
            0: return a & b;
            1: return a | b;
            2: return m - a;
            3: return a ^ b;
            4: return m - (a & b);
            5: return m - (a | b);
            6: return m - (a ^ b);
            default: return (65536 - a) % 65536;
        endcase
    endfunction

    task automatic model_reset();
        exp_out  = 0;
        exp_vld  = 0;
        exp_zero = 1;
        exp_neg  = 0;
        exp_par  = 0;
        exp_ovf  = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out"}, int'(out), exp_out);
        chk({tag, ".out_valid"}, int'(out_valid), int'(exp_vld));
        chk({tag, ".zero"}, int'(zero), int'(exp_zero));
`ifdef LOGICAL_OPS_FLAGS_EN
        chk({tag, ".neg"}, int'(neg), int'(exp_neg));
        chk({tag, ".parity"}, int'(parity), int'(exp_par));
        chk({tag, ".ovf"}, int'(ovf), int'(exp_ovf));
`endif
    endtask

    // Apply one cycle of stimulus, then check the registered outputs just after the edge.
    task automatic drive(input string tag, input bit v, input int a, input int b, input int op);
        int r;
        @(negedge clk);
        in_valid  = v;
        A         = a[WIDTH-1:0];
        B         = b[WIDTH-1:0];
        Operation = op[2:0];
        @(posedge clk);
        #1;
        exp_vld = v;
        if (v) begin
            r        = ref_result(a, b, op);
            exp_out  = r;
            exp_zero = (r == 0);
            exp_neg  = (r >= 32768);
            exp_par  = ($countones(r) % 2) == 1;
            exp_ovf  = (op == 7) && (a == 32768);
        end
        check_outputs(tag);
    endtask

    // Assert reset between clock edges and check it acts without an edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pa [4];
        int pb [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Operation = '0;
        model_reset();
        #12;
        check_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Mid-cycle async reset while out holds 0xFFFF.
        drive("load_ffff", 1, 16'hFFFF, 0, 1);
        async_reset("reset_async");

        // All bitwise opcodes with A=0xFFFF, B=0x2495.
        drive("or",   1, 16'hFFFF, 16'h2495, 1);
        drive("and",  1, 16'hFFFF, 16'h2495, 0);
        drive("xor",  1, 16'hFFFF, 16'h2495, 3);
        drive("nand", 1, 16'hFFFF, 16'h2495, 4);
        drive("nor",  1, 16'hFFFF, 16'h2495, 5);
        drive("xnor", 1, 16'hFFFF, 16'h2495, 6);
        drive("not",  1, 16'hFFFF, 16'h2495, 2);
        drive("idle_pulse", 0, 0, 0, 0);

        // 2s complement, including wrap cases.
        drive("neg_ffff", 1, 16'hFFFF, 0, 7);
        drive("neg_0000", 1, 16'h0000, 16'hFFFF, 7);
        drive("neg_8000", 1, 16'h8000, 0, 7);
        drive("neg_0005", 1, 16'h0005, 0, 7);

        // Hold: outputs stay put while in_valid is low and inputs churn.
        drive("hold_load", 1, 16'h00F0, 16'h0F00, 1);
        for (int i = 0; i < 5; i++)
            drive("hold", 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 7)));

        // Streaming XOR, four back-to-back results.
        pa = '{16'h1234, 16'hAAAA, 16'h0001, 16'hFFFF};
        pb = '{16'h1234, 16'h5555, 16'h0000, 16'h0000};
        for (int i = 0; i < 4; i++)
            drive("stream_xor", 1, pa[i], pb[i], 3);

        // Flag vectors (flags only checked when present).
        drive("flags_and", 1, 16'h8001, 16'hFFFF, 0);
        drive("flags_or",  1, 16'h0007, 16'h0000, 1);

        // Randomized traffic with occasional mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            drive("rand", ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0)
                async_reset("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
